// File: rtl/imem_boot_loader.sv
// Serial boot loader: receives a framed program image over an 8N1 UART line and writes
// 16-bit words into instruction memory, holding the CPU in reset until the image checks out.
//
// state   | meaning
// S_IDLE  | waiting for HEADER after reset
// S_COUNT | next byte is the word count (0 = 256)
// S_HI    | next byte is the high byte of a word
// S_LO    | next byte is the low byte; triggers the write
// S_CSUM  | next byte is the XOR checksum
// S_DONE  | image valid, CPU released; HEADER restarts
// S_ERR   | framing or checksum error; HEADER restarts
module imem_boot_loader #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          ADDR_W       = 8,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_t;
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_CSUM, S_DONE, S_ERR} state_t;

    logic              r_rx_s1, r_rx_s2, r_rx_prev;
    uart_t             r_u_state, w_u_next;
    logic [TW-1:0]     r_tmr;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              w_tmr_zero, w_byte_valid, w_frame_err;

    state_t            r_state, w_next;
    logic              w_accept_hdr;
    logic [8:0]        r_cnt;
    logic [7:0]        r_xor;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic              r_we, r_done, r_err, r_cpu_rst_n;

    assign w_tmr_zero = (r_tmr == '0);

    always_comb begin
        w_u_next     = r_u_state;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        case (r_u_state)
            U_IDLE:  if (r_rx_prev && !r_rx_s2) w_u_next = U_START;
            U_START: if (w_tmr_zero) w_u_next = r_rx_s2 ? U_IDLE : U_DATA;
            U_DATA:  if (w_tmr_zero && (r_bit_idx == 3'd7)) w_u_next = U_STOP;
            U_STOP: begin
                if (w_tmr_zero) begin
                    w_u_next     = U_IDLE;
                    w_byte_valid = r_rx_s2;
                    w_frame_err  = !r_rx_s2;
                end
            end
            default: w_u_next = U_IDLE;
        endcase
    end

    // Timer idles preloaded with the half-bit count so the start re-sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_u_state <= U_IDLE;
            r_tmr     <= HALF_LOAD;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_u_state <= w_u_next;
            if (r_u_state == U_IDLE) begin
                r_tmr     <= HALF_LOAD;
                r_bit_idx <= 3'd0;
            end else if (w_tmr_zero) begin
                r_tmr <= FULL_LOAD;
            end else begin
                r_tmr <= r_tmr - {{(TW-1){1'b0}}, 1'b1};
            end
            if ((r_u_state == U_DATA) && w_tmr_zero) begin
                r_shift   <= {r_rx_s2, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_accept_hdr = 1'b0;
        if (w_frame_err) begin
            w_next = S_ERR;
        end else if (w_byte_valid) begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (r_shift == HEADER) begin
                        w_next       = S_COUNT;
                        w_accept_hdr = 1'b1;
                    end
                end
                S_COUNT: w_next = S_HI;
                S_HI:    w_next = S_LO;
                S_LO:    w_next = (r_cnt == 9'd1) ? S_CSUM : S_HI;
                S_CSUM:  w_next = (r_shift == r_xor) ? S_DONE : S_ERR;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 9'd0;
            r_xor       <= 8'h00;
            r_addr      <= '0;
            r_wdata     <= 16'h0000;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_we        <= 1'b0;
            r_done      <= (r_state == S_DONE);
            r_err       <= (r_state == S_ERR);
            r_cpu_rst_n <= (r_state == S_DONE);
            if (r_we) r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (w_byte_valid) begin
                case (r_state)
                    S_COUNT: r_cnt <= {(r_shift == 8'h00), r_shift};
                    S_HI: begin
                        r_wdata[15:8] <= r_shift;
                        r_xor         <= r_xor ^ r_shift;
                    end
                    S_LO: begin
                        r_wdata[7:0] <= r_shift;
                        r_xor        <= r_xor ^ r_shift;
                        r_we         <= 1'b1;
                        r_cnt        <= r_cnt - 9'd1;
                    end
                    default: ;
                endcase
            end
            if (w_accept_hdr) begin
                r_addr <= '0;
                r_xor  <= 8'h00;
            end
        end
    end

    assign im_we     = r_we;
    assign im_addr   = r_addr;
    assign im_wdata  = r_wdata;
    assign cpu_rst_n = r_cpu_rst_n;
    assign done      = r_done;
    assign err       = r_err;
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Serial boot loader upstream of the single-cycle CPU's instruction memory.
- Receives a framed program image over a UART line (8N1), assembles 16-bit instruction words and writes them sequentially into instruction memory.
- Holds the CPU core in reset until a complete image with a valid checksum has been loaded.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be at least 4.
- ADDR_W, 8, instruction memory address width (matches the 8-bit PC).
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  UART serial input, idle high, asynchronous to clk
- im_we  output  1  instruction memory write strobe, one cycle per word
- im_addr  output  ADDR_W  instruction memory write address
- im_wdata  output  16  instruction word to write
- cpu_rst_n  output  1  active-low reset to the CPU core; low while loading
- done  output  1  image loaded and checksum valid
- err  output  1  frame or checksum error latched

Behaviour:
- Reset values: im_we=0, im_addr=0, im_wdata=0, cpu_rst_n=0, done=0, err=0. FSM=IDLE. UART receiver is idle.
- rx input:
  - Passes through a 2-flop synchronizer before use; reset value of both flops is 1.
  - Latency of the synchronizer is not visible at the interface beyond byte timing.
- UART receiver:
  - A falling edge on the synchronized rx starts a byte.
  - Start bit is re-sampled at CLKS_PER_BIT/2. If rx is high there, it is a glitch: return to idle with no error.
  - Data bits are sampled LSB first at mid-bit intervals of CLKS_PER_BIT.
  - Stop bit is sampled at mid-bit. Stop bit = 0 is a framing error: err=1, FSM->ERR.
  - byte_valid pulses for one cycle at the stop-bit sample.
- Frame format: HEADER, COUNT, then COUNT words sent high byte first, then CSUM.
  - COUNT=0 means 256 words.
  - CSUM is the XOR of every byte after COUNT, excluding CSUM itself.
- FSM (transitions occur on byte_valid):
  - IDLE: HEADER -> COUNT state; clear im_addr, clear the running XOR, set done=0, err=0, cpu_rst_n=0. Any other byte is ignored.
  - COUNT: latch word counter -> HI.
  - HI: store the byte in im_wdata[15:8], XOR it into the checksum -> LO.
  - LO: store the byte in im_wdata[7:0], XOR it, assert im_we on the next cycle for exactly 1 cycle with the current im_addr.
    - im_addr increments in the cycle after im_we, wrapping 255->0.
    - Decrement the word counter. Counter reaching 0 -> CSUM, otherwise -> HI.
  - CSUM: byte equals the running XOR -> DONE, otherwise -> ERR.
  - DONE: done=1, cpu_rst_n=1. A HEADER byte restarts loading (same actions as IDLE->COUNT); other bytes are ignored.
  - ERR: err=1, cpu_rst_n=0. Only a HEADER byte leaves ERR, via the IDLE actions.
- cpu_rst_n is registered. It rises in the cycle after entry to DONE and falls in the cycle after a restart HEADER is accepted.
- Behaviour under asynchronous reset:
  - rst_n low at any time, including mid-byte or mid-frame, immediately forces all outputs to their reset values.
  - No partial word is written afterwards.
  - Words already written stay in memory; memory is not cleared.
- A framing error mid-frame aborts the frame. No further im_we occurs until a new HEADER is accepted.
- im_we never asserts outside the LO->write sequence.

Test Plan:
- Reset, then send A5 02 12 34 AB CD, CSUM=12^34^AB^CD=40 -> im_we pulses at (addr 0, 1234) and (addr 1, ABCD); done=1, cpu_rst_n=1, err=0.
- Same frame with CSUM=41 -> both words written, err=1, done=0, cpu_rst_n stays 0. Then resend the valid frame -> done=1, err=0.
- Send bytes 00 FF 5A before A5 01 00 07 07 -> leading bytes ignored; one write (addr 0, 0007); done=1.
- Send A5 00, then 256 words where word i = {i,i}, CSUM=00 -> 256 writes to addr 0..255; im_addr wraps to 0; done=1.
- Send A5 02 11 22, then a byte with stop bit forced 0 -> err=1; only addr 0 written; following bytes produce no im_we.
- Drive rst_n low for 1 cycle in the middle of the LO byte of word 1 -> outputs return to reset values immediately; no write to addr 1; a fresh valid frame loads correctly.
- Apply a 3-cycle low glitch on rx while idle -> no byte_valid, no state change.
